fifo_drain: RTL and testbench



---
 rtl/fifo_drain.sv | 140 ++++++++++++++
 tb/tb_fifo_drain.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for a synchronous FIFO.
// Issues pops, absorbs the FIFO's one-cycle read latency in a 2-entry skid
// buffer, presents words over valid/ready and counts completed handshakes.
module fifo_drain #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_error,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  words_read,
  output logic                  error_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;

  logic       hs;
  logic       capture;
  logic [2:0] committed;

  // A word is on fifo_data whenever the previous cycle popped; ERROR discards it.
  assign capture   = inflight_q & (state_q != ST_ERROR);
  assign out_valid = (occ_q != 2'd0);
  assign hs        = out_valid & out_ready;
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q};

  assign out_data   = head_q;
  assign words_read = words_q;
  assign error_out  = (state_q == ST_ERROR);
  assign words_d    = hs ? words_q + CNT_WIDTH'(1) : words_q;

  // Pop request: only while draining, and only if the skid can absorb the word
  // (a handshake this cycle frees one slot, so pops resume with out_ready).
  always_comb begin
    // NOTE: every signal driven from an always_comb gets a default first, so no latch is inferred.
    fifo_pop = 1'b0;
    if (!reset && (state_q == ST_DRAIN) && !fifo_empty &&
        (committed < 3'd2 + {2'b00, hs})) begin
      fifo_pop = 1'b1;
    end
  end

  // Next-state logic; a FIFO error outranks every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (fifo_error)   state_d = ST_ERROR;
        else if (!enable) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (fifo_error)                           state_d = ST_ERROR;
        else if (enable)                          state_d = ST_DRAIN;
        else if ((occ_q == 2'd0) && !inflight_q) state_d = ST_IDLE;
      end
      default:  state_d = ST_ERROR;
    endcase
  end

  // Skid buffer as a 2-deep FIFO: head is the presented word, tail the next.
  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fifo_pop;
    case ({capture, hs})
      2'b10: begin
        if (occ_q == 2'd0)      head_d = fifo_data;
        else if (occ_q == 2'd1) tail_d = fifo_data;
        if (occ_q != 2'd2)      occ_d  = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_data;
        end else begin
          head_d = tail_q;
          tail_d = fifo_data;
        end
      end
      default: ;
    endcase
    if (state_d == ST_ERROR) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= ST_IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      // NOTE: the skid words are reset too, because out_data must read 0 after reset.
      head_q     <= '0;
      tail_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      words_q    <= words_d;
    end
  end

  // The pop rule must keep the skid from ever needing a third slot.
  assert property (@(posedge clk) disable iff (reset)
    !(capture && !hs && (occ_q == 2'd2)));

  // A pop is never issued against an empty FIFO.
  assert property (@(posedge clk) !(fifo_pop && fifo_empty));

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: a behavioural FIFO feeds the DUT and a
// queue-based reference model predicts every output each cycle.
module tb_fifo_drain;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, fifo_empty, fifo_error, out_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop, out_valid, error_out;
  logic [DW-1:0] out_data;
  logic [CW-1:0] words_read;
  logic          fifo_pop_w, out_valid_w, error_out_w;
  logic [DW-1:0] out_data_w;
  logic [1:0]    words_read_w;

  fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_error(fifo_error), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .words_read(words_read), .error_out(error_out)
  );

  // Same stimulus, 2-bit counter, for the wrap-around check.
  fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_error(fifo_error), .fifo_data(fifo_data), .fifo_pop(fifo_pop_w),
    .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .words_read(words_read_w), .error_out(error_out_w)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] env_q[$];
  logic [DW-1:0] obs_q[$];
  int            pop_count = 0;

  logic          last_pop, last_valid, last_err;
  logic [DW-1:0] last_data;
  logic [CW-1:0] last_words;
  logic [1:0]    last_words_w;

  typedef enum int {M_IDLE, M_DRAIN, M_FLUSH, M_ERROR} mode_e;
  mode_e         m_mode = M_IDLE;
  logic [DW-1:0] m_skid[$];
  bit            m_inflight = 1'b0;
  logic [DW-1:0] m_pending = '0;
  int            m_words = 0;

  task automatic env_sync();
    fifo_empty = (env_q.size() == 0);
  endtask

  task automatic env_push(input logic [DW-1:0] w);
    env_q.push_back(w);
    env_sync();
  endtask

  function automatic mode_e next_mode(mode_e cur, bit en, bit err, int occ, bit infl);
    case (cur)
      M_IDLE:  return en ? M_DRAIN : M_IDLE;
      M_DRAIN: return err ? M_ERROR : (!en ? M_FLUSH : M_DRAIN);
      M_FLUSH: begin
        if (err) return M_ERROR;
        if (en) return M_DRAIN;
        if (occ == 0 && !infl) return M_IDLE;
        return M_FLUSH;
      end
      default: return M_ERROR;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare outputs to the model, advance both.
  task automatic tick(input bit rst, input bit en, input bit rdy, input bit err);
    bit    exp_pop, exp_valid, exp_err, hs, pop_seen;
    int    old_occ;
    bit    old_infl;
    mode_e nm;
    @(negedge clk);
    reset = rst; enable = en; out_ready = rdy; fifo_error = err;
    #1;
    exp_valid = (m_skid.size() != 0);
    hs        = exp_valid && rdy;
    exp_pop   = !rst && (m_mode == M_DRAIN) && (env_q.size() != 0) &&
                (m_skid.size() + int'(m_inflight) - int'(hs) < 2);
    exp_err   = (m_mode == M_ERROR);

    checks++; if (fifo_pop !== exp_pop) begin failures++;
      $display("FAIL pop t=%0t got %b exp %b", $time, fifo_pop, exp_pop); end
    checks++; if (out_valid !== exp_valid) begin failures++;
      $display("FAIL valid t=%0t got %b exp %b", $time, out_valid, exp_valid); end
    checks++; if (error_out !== exp_err) begin failures++;
      $display("FAIL error_out t=%0t got %b exp %b", $time, error_out, exp_err); end
    checks++; if (words_read !== CW'(m_words)) begin failures++;
      $display("FAIL words t=%0t got %0d exp %0d", $time, words_read, CW'(m_words)); end
    checks++; if (words_read_w !== 2'(m_words)) begin failures++;
      $display("FAIL words_w t=%0t got %0d exp %0d", $time, words_read_w, 2'(m_words)); end
    checks++; if ({fifo_pop_w, out_valid_w, error_out_w} !== {exp_pop, exp_valid, exp_err}) begin
      failures++;
      $display("FAIL ctl_w t=%0t got %b%b%b exp %b%b%b", $time, fifo_pop_w, out_valid_w,
               error_out_w, exp_pop, exp_valid, exp_err); end
    if (exp_valid) begin
      checks++; if (out_data !== m_skid[0] || out_data_w !== m_skid[0]) begin failures++;
        $display("FAIL data t=%0t got %0d/%0d exp %0d", $time, out_data, out_data_w, m_skid[0]); end
    end

    last_pop = fifo_pop; last_valid = out_valid; last_err = error_out;
    last_data = out_data; last_words = words_read; last_words_w = words_read_w;
    if (out_valid === 1'b1 && rdy) obs_q.push_back(out_data);
    pop_seen = (fifo_pop === 1'b1);
    if (pop_seen) pop_count++;

    @(posedge clk);
    #1;
    // Reference model advance.
    old_occ  = m_skid.size();
    old_infl = m_inflight;
    if (rst) begin
      m_mode = M_IDLE; m_skid.delete(); m_inflight = 1'b0; m_words = 0;
    end else begin
      if (hs) begin
        void'(m_skid.pop_front());
        m_words++;
      end
      if (m_inflight && m_mode != M_ERROR) m_skid.push_back(m_pending);
      nm = next_mode(m_mode, en, err, old_occ, old_infl);
      if (exp_pop) m_pending = env_q[0];
      m_inflight = exp_pop;
      if (nm == M_ERROR) begin
        m_skid.delete();
        m_inflight = 1'b0;
      end
      m_mode = nm;
      checks++; if (m_skid.size() > 2) begin failures++;
        $display("FAIL skid_depth t=%0t got %0d exp <=2", $time, m_skid.size()); end
    end
    // Behavioural FIFO: read data appears the cycle after a pop.
    if (pop_seen) begin
      checks++;
      if (env_q.size() == 0) begin
        failures++;
        $display("FAIL pop_on_empty t=%0t got pop exp none", $time);
        fifo_data = DW'($urandom);
      end else begin
        fifo_data = env_q.pop_front();
      end
    end else begin
      fifo_data = DW'($urandom);
    end
    env_sync();
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    env_q.delete();
    env_sync();
    obs_q.delete();
    pop_count = 0;
  endtask

  task automatic check_seq(input string name, input logic [DW-1:0] exp_seq[$]);
    checks++;
    if (obs_q.size() != exp_seq.size()) begin
      failures++;
      $display("FAIL %s_len got %0d exp %0d", name, obs_q.size(), exp_seq.size());
    end else begin
      foreach (exp_seq[i]) begin
        checks++;
        if (obs_q[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL %s[%0d] got %0d exp %0d", name, i, obs_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if ({last_pop, last_valid, last_err} !== 3'b000 || last_data !== '0 ||
                  last_words !== '0) begin
      failures++;
      $display("FAIL reset_outputs got pop=%b v=%b e=%b d=%0d w=%0d exp all 0",
               last_pop, last_valid, last_err, last_data, last_words);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_streaming();
    int first_pop, last_pop_i, first_valid;
    first_pop = -1; last_pop_i = -1; first_valid = -1;
    do_reset();
    env_push(6'd7); env_push(6'd6); env_push(6'd5); env_push(6'd4);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      if (last_pop === 1'b1) begin
        if (first_pop < 0) first_pop = i;
        last_pop_i = i;
      end
      if (last_valid === 1'b1 && first_valid < 0) first_valid = i;
    end
    checks++; if (pop_count != 4 || last_pop_i - first_pop != 3) begin failures++;
      $display("FAIL stream_pops got %0d span %0d exp 4 span 3", pop_count, last_pop_i - first_pop); end
    checks++; if (first_valid - first_pop != 2) begin failures++;
      $display("FAIL stream_latency got %0d exp 2", first_valid - first_pop); end
    checks++; if (last_words !== CW'(4) || last_pop !== 1'b0) begin failures++;
      $display("FAIL stream_end got w=%0d pop=%b exp 4 0", last_words, last_pop); end
    check_seq("stream_seq", '{6'd7, 6'd6, 6'd5, 6'd4});
  endtask

  task automatic test_backpressure();
    do_reset();
    env_push(6'd7); env_push(6'd6); env_push(6'd5); env_push(6'd4);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (pop_count != 2) begin failures++;
      $display("FAIL bp_pops got %0d exp 2", pop_count); end
    checks++; if (last_valid !== 1'b1 || last_data !== 6'd7) begin failures++;
      $display("FAIL bp_hold got v=%b d=%0d exp 1 7", last_valid, last_data); end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check_seq("bp_seq", '{6'd7, 6'd6, 6'd5, 6'd4});
  endtask

  task automatic test_enable_drop();
    do_reset();
    env_push(6'd7); env_push(6'd6); env_push(6'd5);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (env_q.size() != 2 || pop_count != 1) begin failures++;
      $display("FAIL drop_left got %0d pops %0d exp 2 1", env_q.size(), pop_count); end
    checks++; if (last_words !== CW'(1) || last_valid !== 1'b0) begin failures++;
      $display("FAIL drop_words got %0d v=%b exp 1 0", last_words, last_valid); end
    check_seq("drop_seq", '{6'd7});
  endtask

  task automatic test_error();
    do_reset();
    for (int i = 0; i < 6; i++) env_push(DW'(10 + i));
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'($urandom), 1'b1, 1'b0);
      checks++; if ({last_err, last_valid, last_pop} !== 3'b100) begin failures++;
        $display("FAIL err_hold got e=%b v=%b p=%b exp 1 0 0", last_err, last_valid, last_pop); end
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if ({last_err, last_valid, last_pop} !== 3'b000 || last_data !== '0 ||
                  last_words !== '0) begin
      failures++;
      $display("FAIL err_reset got e=%b v=%b p=%b d=%0d w=%0d exp all 0",
               last_err, last_valid, last_pop, last_data, last_words);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    env_push(6'd7); env_push(6'd6); env_push(6'd5); env_push(6'd4);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (last_pop !== 1'b0) begin failures++;
      $display("FAIL mid_pop_in_reset got %b exp 0", last_pop); end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if ({last_err, last_valid, last_pop} !== 3'b000 || last_data !== '0 ||
                  last_words !== '0) begin
      failures++;
      $display("FAIL mid_reset got e=%b v=%b p=%b d=%0d w=%0d exp all 0",
               last_err, last_valid, last_pop, last_data, last_words);
    end
    obs_q.delete();
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check_seq("mid_seq", '{6'd6, 6'd5, 6'd4});
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) env_push(DW'($urandom));
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (last_words !== CW'(5) || last_words_w !== 2'd1) begin failures++;
      $display("FAIL wrap got %0d/%0d exp 5/1", last_words, last_words_w); end
  endtask

  task automatic test_random();
    bit rst, en, rdy, err;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (env_q.size() < 4 && $urandom_range(0, 2) == 0) env_push(DW'($urandom));
      rst = ($urandom_range(0, 99) == 0) || (m_mode == M_ERROR && $urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 4) > 1);
      err = ($urandom_range(0, 149) == 0);
      tick(rst, en, rdy, err);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; fifo_error = 1'b0; fifo_data = '0;
    env_sync();
    repeat (2) @(posedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_enable_drop();
    test_error();
    test_reset_midburst();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
